// File: rtl/scan_decoder_pkg.sv
// Shared mode encodings and controller state type for the scanning one-hot decoder.
package scan_decoder_pkg;

  localparam logic [1:0] MODE_DIRECT  = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP = 2'b01;
  localparam logic [1:0] MODE_SCAN_DN = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_DIRECT = 2'b01,
    ST_SCAN   = 2'b10,
    ST_HOLD   = 2'b11
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder.
module onehot_dec #(
  parameter int unsigned SEL_W = 4
) (
  input  logic [SEL_W-1:0]    idx,
  output logic [2**SEL_W-1:0] vec
);

  always_comb begin
    vec      = '0;
    vec[idx] = 1'b1;
  end

endmodule

// File: rtl/scan_decoder.sv
// One-hot output decoder with direct select, timed up/down scanning and hold.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned OUT_W   = 2**SEL_W,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SEL_W-1:0]   last,
  output logic [OUT_W-1:0]   out,
  output logic [SEL_W-1:0]   idx,
  output logic               valid,
  output logic               wrap
);

  state_t             state, state_d;
  logic [DWELL_W-1:0] cnt, cnt_d, cnt_cur;
  logic [SEL_W-1:0]   idx_d;
  logic               wrap_d;
  logic [OUT_W-1:0]   dec_vec, out_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next state: en low wins over mode
  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      case (mode)
        MODE_DIRECT:                 state_d = ST_DIRECT;
        MODE_SCAN_UP, MODE_SCAN_DN:  state_d = ST_SCAN;
        default:                     state_d = ST_HOLD;
      endcase
    end
  end

  // Next index, dwell count and wrap; a fresh scan entry starts counting from zero
  always_comb begin
    idx_d   = idx;
    cnt_d   = cnt;
    wrap_d  = 1'b0;
    cnt_cur = (state == ST_SCAN) ? cnt : '0;
    case (state_d)
      ST_IDLE: cnt_d = '0;
      ST_DIRECT: begin
        idx_d = sel;
        cnt_d = '0;
      end
      ST_SCAN: begin
        if (cnt_cur >= dwell) begin
          cnt_d = '0;
          if (mode == MODE_SCAN_UP) begin
            if (idx >= last) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = SEL_W'(idx + 1'b1);
            end
          end else begin
            if (idx == '0) begin
              idx_d  = last;
              wrap_d = 1'b1;
            end else if (idx > last) begin
              idx_d = last;
            end else begin
              idx_d = SEL_W'(idx - 1'b1);
            end
          end
        end else begin
          cnt_d = DWELL_W'(cnt_cur + 1'b1);
        end
      end
      default: ;
    endcase
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .idx (idx_d),
    .vec (dec_vec)
  );

  assign out_d = (state_d == ST_IDLE) ? '0 : dec_vec;

  // Registered datapath and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      out   <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      cnt   <= cnt_d;
      idx   <= idx_d;
      out   <= out_d;
      valid <= |out_d;
      wrap  <= wrap_d;
    end
  end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter SEL_W, default 4, SHALL set the select/index width (legal range 1..6).
REQ-002 Parameter OUT_W, default 2**SEL_W, SHALL be derived from SEL_W and never overridden.
REQ-003 Parameter DWELL_W, default 8, SHALL set the dwell-count width.
REQ-004 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-005 Port clk, input, 1 bit: sole clock, rising edge.
REQ-006 Port rst, input, 1 bit: synchronous active-high reset.
REQ-007 Port en, input, 1 bit: output enable; 0 forces the output to zero.
REQ-008 Port mode, input, 2 bits: 00 DIRECT, 01 SCAN_UP, 10 SCAN_DN, 11 HOLD.
REQ-009 Port sel, input, SEL_W bits: index decoded in DIRECT mode.
REQ-010 Port dwell, input, DWELL_W bits: a scan step occurs every dwell+1 cycles.
REQ-011 Port last, input, SEL_W bits: highest index visited in scan modes.
REQ-012 Port out, output, OUT_W bits: registered one-hot decode of idx, or all zero.
REQ-013 Port idx, output, SEL_W bits: current registered index.
REQ-014 Port valid, output, 1 bit: 1 when out is non-zero.
REQ-015 Port wrap, output, 1 bit: one-cycle pulse when a scan wraps.

Function
REQ-016 Every output SHALL be registered; out SHALL always be all-zero or exactly one-hot, OUT_W bits wide, with bit k set only when idx==k.
REQ-017 States: IDLE (en=0), DIRECT, SCAN (SCAN_UP or SCAN_DN), HOLD; the state SHALL be re-evaluated every cycle from en and mode, and en=0 SHALL take priority over mode.
REQ-018 IDLE: out=0 and valid=0 on the next edge; idx held; dwell counter cleared; wrap=0.
REQ-019 DIRECT: idx<=sel and out<=onehot(sel), giving 1-cycle latency from sel to out; the dwell counter SHALL be held at 0.
REQ-020 SCAN: the dwell counter SHALL count 0..dwell; idx SHALL step only on the cycle the counter equals dwell, and the counter SHALL return to 0 on that cycle.
REQ-021 dwell=0: idx SHALL step every cycle.
REQ-022 SCAN_UP step: if idx>=last, idx<=0 and wrap=1; otherwise idx<=idx+1.
REQ-023 SCAN_DN step: if idx==0 or idx>last, idx<=last; wrap=1 only when idx was 0; otherwise idx<=idx-1.
REQ-024 last=0: idx SHALL stay 0, and wrap SHALL pulse on every step.
REQ-025 Entering SCAN from any other state SHALL start from the current idx with the counter at 0; the first step occurs dwell+1 cycles later.
REQ-026 SCAN_UP<->SCAN_DN switch: direction SHALL change on the next step; the counter SHALL NOT be cleared.
REQ-027 HOLD: idx and counter frozen; out=onehot(idx); wrap=0.
REQ-028 Changing dwell mid-count: the new value SHALL be compared immediately; if the counter is >= the new dwell, the step SHALL occur on the next cycle.
REQ-029 wrap SHALL be asserted only in SCAN, in the same cycle that idx shows the wrapped value.
REQ-030 valid SHALL equal |out, registered with out.

Reset
REQ-031 With rst=1 on a clock edge: out=0, idx=0, valid=0, wrap=0, dwell counter=0, state=IDLE.
REQ-032 rst SHALL override en and mode, including in the middle of a dwell period or scan.
REQ-033 The first cycle after rst falls SHALL behave as entry from IDLE (REQ-025 applies).

Structure
REQ-034 A shared package scan_decoder_pkg SHALL hold the mode encodings (MODE_DIRECT, MODE_SCAN_UP, MODE_SCAN_DN, MODE_HOLD) and the state enum.
REQ-035 The combinational one-hot decoder SHALL be a sub-module onehot_dec (parameter SEL_W; input idx; output OUT_W-bit vector), instantiated once.
REQ-036 The state register, dwell counter and index register SHALL be in scan_decoder.

Verification
REQ-037 DIRECT, en=1, SEL_W=4, sel sweeps 0..15 -> out=1<<sel one cycle later for all 16 values; valid=1.
REQ-038 SCAN_UP, dwell=2, last=5, from idx=0 -> idx steps every 3 cycles: 1,2,3,4,5,0; wrap=1 only on the cycle idx becomes 0.
REQ-039 SCAN_DN, dwell=0, last=3, idx=0 -> idx 3,2,1,0,3 on consecutive cycles; wrap=1 on the 0->3 step only.
REQ-040 SCAN_UP with idx=9, then last changed to 4 -> next step idx=0, wrap=1.
REQ-041 en dropped mid-scan for 5 cycles, then restored -> out=0 and valid=0 during the drop; idx retained; first step dwell+1 cycles after restore.
REQ-042 rst asserted mid-dwell in SCAN_UP with idx=7 -> next cycle out=0, idx=0, wrap=0, valid=0.
